// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift execution unit.
// Rotate support is enabled by defining SHIFT_EXEC_ROT_EN at build time.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    localparam int XLEN_DEFAULT = 64;
    localparam int SHAMT_W      = $clog2(XLEN_DEFAULT);

    // Widest datapath the reverse helper supports; callers right-align their slice.
    localparam int REV_MAX = 256;

    function automatic logic [REV_MAX-1:0] bit_rev(input logic [REV_MAX-1:0] x);
        logic [REV_MAX-1:0] r;
        for (int i = 0; i < REV_MAX; i++) begin
            r[i] = x[REV_MAX-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational log-stage arithmetic right shifter; stage gi shifts by 2**gi.
module shift_core #(
    parameter int W  = 65,
    parameter int SW = $clog2(W)
) (
    input  logic [W-1:0]  data,
    input  logic [SW-1:0] shamt,
    output logic [W-1:0]  result
);

    logic [W-1:0] stage [0:SW];

    assign stage[0] = data;

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign stage[gi+1] = shamt[gi]
                ? {{STEP{stage[gi][W-1]}}, stage[gi][W-1:STEP]}
                : stage[gi];
        end
    endgenerate

    assign result = stage[SW];

endmodule

// File: rtl/shift_exec.sv
// Two-stage RV64 shift unit (SLL/SRL/SRA and W forms) built on one arithmetic right shifter.
// Defining SHIFT_EXEC_ROT_EN turns op 11 into ROR/RORW; otherwise op 11 yields zero.
module shift_exec
    import shift_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic                     in_word,
    input  logic [XLEN-1:0]          in_rs1,
    input  logic [$clog2(XLEN)-1:0]  in_shamt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_result,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SH_W      = $clog2(XLEN);
    localparam int CORE_SH_W = $clog2(XLEN + 1);

    logic              s1_valid_reg;
    logic [XLEN:0]     s1_operand_reg;
    logic [SH_W-1:0]   s1_shamt_reg;
    shift_op_e         s1_op_reg;
    logic              s1_word_reg;
    logic [TAG_W-1:0]  s1_tag_reg;

    logic              out_valid_reg;
    logic [XLEN-1:0]   out_result_reg;
    logic [TAG_W-1:0]  out_tag_reg;

    shift_op_e         op_next;
    logic              fill32;
    logic [XLEN-1:0]   base_v;
    logic [XLEN-1:0]   prep_v;
    logic [SH_W-1:0]   shamt_next;
    logic [XLEN:0]     operand_next;
    logic [XLEN:0]     shifted;
    logic [XLEN-1:0]   shifted_low;
    logic              shifted_top_unused;
    logic [XLEN-1:0]   result_next;
    logic              s1_advance;

    assign s1_advance = !out_valid_reg || out_ready;
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_tag    = out_tag_reg;

    // Operand preparation: word-adjust, reverse for left shifts, prepend the sign fill.
    always_comb begin
        op_next    = shift_op_e'(in_op);
        fill32     = (op_next == SH_SRA) && in_rs1[31];
        base_v     = in_rs1;
        shamt_next = in_shamt;
        if (in_word) begin
            for (int i = 32; i < XLEN; i++) base_v[i] = fill32;
            for (int i = 5; i < SH_W; i++) shamt_next[i] = 1'b0;
        end
        prep_v = (op_next == SH_SLL)
            ? XLEN'(bit_rev(REV_MAX'(base_v)) >> (REV_MAX - XLEN))
            : base_v;
        operand_next = {(op_next == SH_SRA) && prep_v[XLEN-1], prep_v};
    end

    shift_core #(
        .W  (XLEN + 1),
        .SW (CORE_SH_W)
    ) u_core (
        .data   (s1_operand_reg),
        .shamt  ({{(CORE_SH_W - SH_W){1'b0}}, s1_shamt_reg}),
        .result (shifted)
    );

    assign shifted_low        = shifted[XLEN-1:0];
    assign shifted_top_unused = shifted[XLEN];

    always_comb begin
        result_next = (s1_op_reg == SH_SLL)
            ? XLEN'(bit_rev(REV_MAX'(shifted_low)) >> (REV_MAX - XLEN))
            : shifted_low;
`ifdef SHIFT_EXEC_ROT_EN
        // Rotate as a right shift of the doubled operand.
        if (s1_op_reg == SH_ROR) begin
            result_next = s1_word_reg
                ? XLEN'(32'({s1_operand_reg[31:0], s1_operand_reg[31:0]} >> s1_shamt_reg))
                : XLEN'({s1_operand_reg[XLEN-1:0], s1_operand_reg[XLEN-1:0]} >> s1_shamt_reg);
        end
`else
        if (s1_op_reg == SH_ROR) result_next = '0;
`endif
        if (s1_word_reg) begin
            for (int i = 32; i < XLEN; i++) result_next[i] = result_next[31];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_tag_reg    <= '0;
        end else begin
            if (in_ready) s1_valid_reg <= in_valid;
            if (s1_advance) out_valid_reg <= s1_valid_reg;
            if (s1_advance && s1_valid_reg) begin
                out_result_reg <= result_next;
                out_tag_reg    <= s1_tag_reg;
            end
        end
    end

    // Stage-1 payload needs no reset: it is qualified by s1_valid_reg.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_operand_reg <= operand_next;
            s1_shamt_reg   <= shamt_next;
            s1_op_reg      <= op_next;
            s1_word_reg    <= in_word;
            s1_tag_reg     <= in_tag;
        end
    end

endmodule
